// File: rtl/if_fifo_pkg.sv
// -----------------------------------------------------------------------------
// if_fifo_pkg
// Shared definitions for the instruction fetch buffer:
//   - ctrl hold levels (Hold_None .. Hold_Id)
//   - instruction / address bus types and the canonical NOP (addi x0,x0,0)
//   - the queued entry layout {addr, inst}
// -----------------------------------------------------------------------------
package if_fifo_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int HOLD_W      = 3;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [HOLD_W-1:0]      hold_flag_t;

  // Hold levels issued by ctrl; any level at or above HOLD_ID freezes IF/ID.
  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  localparam inst_addr_t ZERO_WORD = '0;
  localparam inst_t      INST_NOP  = 32'h0000_0013;

  // One queued fetch word. The address sits in the upper half.
  typedef struct packed {
    inst_addr_t addr;
    inst_t      inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo_if.sv
// -----------------------------------------------------------------------------
// if_fifo_if
// Bundles the fetch-side inputs and IF/ID-side outputs of if_fifo.
//   slave  : the buffer itself (consumes fetch words, drives IF/ID + status)
//   master : whoever drives fetch/ctrl and observes IF/ID
// Signals:
//   inst_addr_i, inst_i, inst_valid_i : fetched word from the icache pipeline
//   jump_flag_i                       : flush request
//   hold_flag_i                       : ctrl hold level
//   inst_addr_o, inst_o, inst_valid_o : IF/ID register
//   afull_o, count_o, ovf_o           : registered status toward ctrl
// -----------------------------------------------------------------------------
interface if_fifo_if #(
  parameter int DEPTH = 4
);
  import if_fifo_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  inst_addr_t       inst_addr_i;
  inst_t            inst_i;
  logic             inst_valid_i;
  logic             jump_flag_i;
  hold_flag_t       hold_flag_i;

  inst_addr_t       inst_addr_o;
  inst_t            inst_o;
  logic             inst_valid_o;
  logic             afull_o;
  logic [CNT_W-1:0] count_o;
  logic             ovf_o;

  modport slave (
    input  inst_addr_i, inst_i, inst_valid_i, jump_flag_i, hold_flag_i,
    output inst_addr_o, inst_o, inst_valid_o, afull_o, count_o, ovf_o
  );

  modport master (
    output inst_addr_i, inst_i, inst_valid_i, jump_flag_i, hold_flag_i,
    input  inst_addr_o, inst_o, inst_valid_o, afull_o, count_o, ovf_o
  );

endinterface

// File: rtl/if_fifo_mem.sv
// -----------------------------------------------------------------------------
// if_fifo_mem
// DEPTH x 64-bit storage for the fetch buffer: one synchronous write port,
// one asynchronous read port (the queue head is visible combinationally).
// Ports:
//   clk        : core clock
//   wr_en_i    : write enable
//   wr_ptr_i   : write index
//   wr_data_i  : entry to store
//   rd_ptr_i   : read index
//   rd_data_o  : entry at rd_ptr_i
// -----------------------------------------------------------------------------
module if_fifo_mem
  import if_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  fetch_entry_t     wr_data_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output fetch_entry_t     rd_data_o
);

  fetch_entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; count gates every read, so stale contents
  // are never observed and the array can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Instruction fetch buffer between the fetch stage and decode. Words that
// arrive while decode is held are queued; when decode advances, the queue
// head (or, if empty, the incoming word directly) loads the IF/ID register.
// A jump flushes everything. afull_o lets ctrl hold pc early enough that the
// words still in the icache pipeline fit.
// DEPTH must be a power of two, at least 2.
// Ports:
//   clk               : core clock
//   rst               : synchronous active-high reset
//   jtag_reset_flag_i : second reset source, same effect as rst
//   bus               : if_fifo_if.slave (fetch inputs, IF/ID + status out)
// -----------------------------------------------------------------------------
module if_fifo
  import if_fifo_pkg::*;
#(
  parameter int    DEPTH        = 4,
  parameter int    AFULL_MARGIN = 2,
  parameter inst_t NOP_INST     = INST_NOP
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     jtag_reset_flag_i,
  if_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam fetch_entry_t NOP_ENTRY = '{addr: ZERO_WORD, inst: NOP_INST};

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  fetch_entry_t     out_q,    out_d;
  logic             out_valid_q, out_valid_d;
  logic             afull_q,  afull_d;
  logic             ovf_q,    ovf_d;

  logic         sync_rst;
  logic         advance;
  logic         wr_en;
  fetch_entry_t wr_data;
  fetch_entry_t rd_data;

  assign sync_rst = rst | jtag_reset_flag_i;
  assign advance  = (bus.hold_flag_i < HOLD_ID);
  assign wr_data  = '{addr: bus.inst_addr_i, inst: bus.inst_i};

  if_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;

    if (bus.jump_flag_i) begin
      // Flush wins over push, pop and hold; the incoming word is discarded.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_d       = NOP_ENTRY;
      out_valid_d = 1'b0;
    end else if (advance) begin
      if (count_q != '0) begin
        // Pop the head; a simultaneous push keeps count unchanged, so a
        // full queue still accepts a word on a pop cycle.
        out_d       = rd_data;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        if (bus.inst_valid_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else if (bus.inst_valid_i) begin
        // Empty queue: bypass straight into IF/ID for 1-cycle latency.
        out_d       = wr_data;
        out_valid_d = 1'b1;
      end else begin
        out_d       = NOP_ENTRY;
        out_valid_d = 1'b0;
      end
    end else if (bus.inst_valid_i) begin
      // Decode frozen: queue the in-flight word, or record the drop.
      if (count_q != FULL_CNT) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Evaluated on the next count so the registered flag tracks count_o.
    afull_d = ((DEPTH - int'(count_d)) <= AFULL_MARGIN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from the same edge, independent of block order.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= NOP_ENTRY;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.inst_addr_o  = out_q.addr;
  assign bus.inst_o       = out_q.inst;
  assign bus.inst_valid_o = out_valid_q;
  assign bus.afull_o      = afull_q;
  assign bus.count_o      = count_q;
  assign bus.ovf_o        = ovf_q;

endmodule

// File: tb/tb_if_fifo.sv
// -----------------------------------------------------------------------------
// tb_if_fifo
// Self-checking bench for if_fifo (DEPTH=4, AFULL_MARGIN=2). Words the bench
// expects decode to see are queued in order when driven and compared against
// IF/ID on every cycle where decode advances.
// -----------------------------------------------------------------------------
module tb_if_fifo;
  import if_fifo_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic jtag;

  if_fifo_if #(.DEPTH(DEPTH)) bus ();

  if_fifo #(
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (2),
    .NOP_INST     (NOP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .jtag_reset_flag_i (jtag),
    .bus               (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  // One clock of stimulus. acc: the bench expects this word to reach decode.
  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] i,
                      input logic [2:0] h, input logic j, input logic acc);
    logic [63:0] exp_w;
    bus.inst_valid_i = v;
    bus.inst_addr_i  = a;
    bus.inst_i       = i;
    bus.hold_flag_i  = h;
    bus.jump_flag_i  = j;
    if (j) sb_q.delete();
    else if (acc) sb_q.push_back({a, i});
    @(posedge clk);
    #1;
    if (!j && h < 3'd3) begin
      total++;
      if (bus.inst_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got addr=%h inst=%h, required no valid output",
                   bus.inst_addr_o, bus.inst_o);
        end else begin
          exp_w = sb_q.pop_front();
          if ({bus.inst_addr_o, bus.inst_o} !== exp_w) begin
            bad++;
            $display("FAIL sb_order: got addr=%h inst=%h, required addr=%h inst=%h",
                     bus.inst_addr_o, bus.inst_o, exp_w[63:32], exp_w[31:0]);
          end
        end
      end else if (bus.inst_valid_o !== 1'b0 || sb_q.size() != 0 || bus.inst_o !== NOP) begin
        bad++;
        $display("FAIL sb_idle: got valid=%b inst=%h, required valid=0 inst=%h with %0d words pending",
                 bus.inst_valid_o, bus.inst_o, NOP, sb_q.size());
      end
    end
    bus.inst_valid_i = 1'b0;
    bus.jump_flag_i  = 1'b0;
  endtask

  task automatic do_reset(input logic use_jtag);
    sb_q.delete();
    bus.inst_valid_i = 1'b0;
    bus.jump_flag_i  = 1'b0;
    bus.hold_flag_i  = 3'd0;
    if (use_jtag) jtag = 1'b1;
    else          rst  = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    jtag = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b0, 32'h0, NOP}) begin
      bad++;
      $display("FAIL %s_ifid: got valid=%b addr=%h inst=%h, required 0/0/%h",
               tag, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, NOP);
    end
    total++;
    if ({bus.count_o, bus.afull_o, bus.ovf_o} !== 5'b000_0_0) begin
      bad++;
      $display("FAIL %s_status: got count=%0d afull=%b ovf=%b, required 0/0/0",
               tag, bus.count_o, bus.afull_o, bus.ovf_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    jtag = 1'b0;
    do_reset(1'b0);
    check_reset_state("reset");
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 4; c++) tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 32'h0, 32'h0050_0093, 3'd0, 1'b0, 1'b1);
    total++;
    if ({bus.inst_valid_o, bus.inst_o, bus.count_o} !== {1'b1, 32'h0050_0093, 3'd0}) begin
      bad++;
      $display("FAIL bypass: got valid=%b inst=%h count=%0d, required 1/00500093/0",
               bus.inst_valid_o, bus.inst_o, bus.count_o);
    end
  endtask

  task automatic test_stall_fill();
    logic [2:0] exp_cnt[3]  = '{3'd1, 3'd2, 3'd3};
    logic       exp_full[3] = '{1'b0, 1'b1, 1'b1};
    tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 32'(4 * (k + 1)), 32'h1000_0000 + 32'(k), 3'd3, 1'b0, 1'b1);
      total++;
      if ({bus.count_o, bus.afull_o} !== {exp_cnt[k], exp_full[k]}) begin
        bad++;
        $display("FAIL fill_%0d: got count=%0d afull=%b, required %0d/%b",
                 k, bus.count_o, bus.afull_o, exp_cnt[k], exp_full[k]);
      end
    end
    for (int k = 0; k < 4; k++) tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    total++;
    if ({bus.count_o, bus.afull_o} !== 4'b000_0) begin
      bad++;
      $display("FAIL fill_drained: got count=%0d afull=%b, required 0/0", bus.count_o, bus.afull_o);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++)
      tick(1'b1, 32'h20 + 32'(4 * k), $urandom, 3'd3, 1'b0, k < 4);
    total++;
    if ({bus.count_o, bus.afull_o, bus.ovf_o} !== 5'b100_1_1) begin
      bad++;
      $display("FAIL ovf_full: got count=%0d afull=%b ovf=%b, required 4/1/1",
               bus.count_o, bus.afull_o, bus.ovf_o);
    end
    for (int k = 0; k < 5; k++) tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    total++;
    if (bus.ovf_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got ovf=%b, required 1", bus.ovf_o);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++)
      tick(1'b1, 32'h40 + 32'(4 * k), $urandom, 3'd3, 1'b0, 1'b1);
    total++;
    if (bus.count_o !== 3'd3) begin
      bad++;
      $display("FAIL flush_pre: got count=%0d, required 3", bus.count_o);
    end
    tick(1'b1, 32'h50, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0);
    total++;
    if ({bus.count_o, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.ovf_o} !==
        {3'd0, 1'b0, 32'h0, NOP, 1'b1}) begin
      bad++;
      $display("FAIL flush: got count=%0d valid=%b addr=%h inst=%h ovf=%b, required 0/0/0/%h/1",
               bus.count_o, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.ovf_o, NOP);
    end
    tick(1'b1, 32'h100, 32'h0010_0113, 3'd0, 1'b0, 1'b1);
    total++;
    if ({bus.inst_valid_o, bus.count_o} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL flush_bypass: got valid=%b count=%0d, required 1/0", bus.inst_valid_o, bus.count_o);
    end
    tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    do_reset(1'b0);
    for (int k = 0; k < 4; k++)
      tick(1'b1, 32'h60 + 32'(4 * k), $urandom, 3'd3, 1'b0, 1'b1);
    total++;
    if ({bus.count_o, bus.ovf_o} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL fpp_pre: got count=%0d ovf=%b, required 4/0", bus.count_o, bus.ovf_o);
    end
    tick(1'b1, 32'h70, 32'hCAFE_0001, 3'd0, 1'b0, 1'b1);
    total++;
    if ({bus.count_o, bus.ovf_o, bus.inst_valid_o} !== {3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL fpp: got count=%0d ovf=%b valid=%b, required 4/0/1",
               bus.count_o, bus.ovf_o, bus.inst_valid_o);
    end
    for (int k = 0; k < 5; k++) tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 5; k++)
      tick(1'b1, 32'h80 + 32'(4 * k), $urandom, 3'd3, 1'b0, k < 4);
    tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    total++;
    if ({bus.count_o, bus.ovf_o} !== {3'd2, 1'b1}) begin
      bad++;
      $display("FAIL mid_pre: got count=%0d ovf=%b, required 2/1", bus.count_o, bus.ovf_o);
    end
    do_reset(1'b1);
    check_reset_state("jtag_reset");
    tick(1'b1, 32'h200, 32'h0020_0213, 3'd0, 1'b0, 1'b1);
    total++;
    if ({bus.inst_valid_o, bus.count_o} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL mid_bypass: got valid=%b count=%0d, required 1/0", bus.inst_valid_o, bus.count_o);
    end
    tick(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst              = 1'b1;
    jtag             = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.inst_addr_i  = '0;
    bus.inst_i       = '0;
    bus.jump_flag_i  = 1'b0;
    bus.hold_flag_i  = 3'd0;
    test_reset();
    test_bypass();
    test_stall_fill();
    test_overflow();
    test_flush();
    test_full_push_pop();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
